data_tx_serializer: RTL and testbench
=====================================

DATA_TX_SERIALIZER -- requirements
Module: data_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, Clk cycles per serial bit, legal range 1..255.
REQ-003 SHALL have parameter PARITY_EN, default 1; 1 = even parity bit inserted, 0 = no parity bit.
REQ-004 SHALL have port Clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset (Reset=0 resets on the next Clk edge).
REQ-006 SHALL have port TxData  input  1  transmit request from the memory-flow controller.
REQ-007 SHALL have port DataIn  input  DATA_W  word to send, valid in the cycle TxData is accepted.
REQ-008 SHALL have port SerialOut  output  1  serial line, idle high.
REQ-009 SHALL have port TxDone  output  1  one-cycle pulse at frame completion, returned to the controller.
REQ-010 SHALL have port TxBusy  output  1  high from the accept edge until the cycle after the TxDone pulse.

Function
REQ-011 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, DONE.
REQ-012 IDLE with TxData=1 SHALL, on that edge, latch DataIn into the shift register, clear the bit counter, and enter START.
REQ-013 SHALL ignore TxData in every state except IDLE; DataIn changes after acceptance SHALL NOT affect the frame.
REQ-014 SerialOut SHALL be registered: 1 in IDLE/DONE, 0 in START, shift[0] in DATA, parity in PARITY, 1 in STOP.
REQ-015 Each of START, each DATA bit, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded at every bit boundary.
REQ-016 DATA SHALL send LSB first, shifting right once per bit boundary, and leave after DATA_W bits.
REQ-017 DATA SHALL go to PARITY when PARITY_EN=1, otherwise directly to STOP.
REQ-018 The parity bit SHALL equal the XOR of the latched word (even parity), computed from the value captured at accept time.
REQ-019 STOP SHALL go to DONE; DONE SHALL last exactly one cycle with TxDone=1, then return to IDLE.
REQ-020 Accept-to-TxDone latency SHALL be (2+DATA_W+PARITY_EN)*CLKS_PER_BIT+1 cycles; defaults give 45.
REQ-021 TxData still high in the IDLE cycle after DONE SHALL start a new frame (back-to-back frames, one idle-high cycle between STOP and the next START).
REQ-022 The bit-cycle counter SHALL be wide enough for CLKS_PER_BIT; the bit index counter SHALL be wide enough for DATA_W and SHALL never wrap mid-frame.
REQ-023 With CLKS_PER_BIT=1 the block SHALL emit one bit per cycle with no dropped or repeated bits.

Reset
REQ-024 Reset=0 SHALL, on the next edge, force IDLE, SerialOut=1, TxDone=0, TxBusy=0, and clear the shift register and all counters.
REQ-025 Reset=0 mid-frame SHALL abort the frame without emitting TxDone; the first post-reset frame SHALL be complete and correct.
REQ-026 Reset SHALL take priority over TxData in the same cycle.

Structure
REQ-027 The state encoding (3-bit localparams) and the default DATA_W/CLKS_PER_BIT values SHALL reside in the shared package tx_pkg.
REQ-028 The bit-period counter SHALL be a sub-module tx_bit_timer (inputs Clk, Reset, load; output tick), instantiated once.

Verification
REQ-029 Defaults, DataIn=8'hA5, 1-cycle TxData pulse -> SerialOut per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1; TxDone high on cycle 45 only.
REQ-030 DataIn=8'h07, PARITY_EN=1 -> parity bit 1; PARITY_EN=0 build -> no parity slot, TxDone on cycle 41.
REQ-031 TxData pulsed again at cycles 5 and 20 of a frame -> ignored; exactly one TxDone; DataIn changed to 8'hFF at cycle 2 -> frame still carries 8'hA5.
REQ-032 TxData held high across DONE -> second frame START begins two cycles after the TxDone cycle; two TxDone pulses 46 cycles apart.
REQ-033 Reset=0 for one cycle during DATA bit 3 -> next edge SerialOut=1, TxBusy=0, no TxDone; subsequent 8'h3C frame correct.
REQ-034 CLKS_PER_BIT=1, DataIn=8'h81 -> SerialOut 0,1,0,0,0,0,0,0,1,0,1 on consecutive cycles; TxDone on cycle 12.

Source files
------------

// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared defaults and state encoding for the serial transmitter
package tx_pkg;

    localparam int TX_DATA_W       = 8;
    localparam int TX_CLKS_PER_BIT = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP,
        DONE   = ST_DONE
    } tx_state_t;

endpackage

// File: rtl/tx_bit_timer.sv
// rtl/tx_bit_timer.sv - bit-period down-counter, tick marks the last cycle of a bit
module tx_bit_timer
    import tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Reload at every bit boundary, then count down and hold at zero.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/data_tx_serializer.sv
// rtl/data_tx_serializer.sv - framed LSB-first serializer with optional even parity
module data_tx_serializer
    import tx_pkg::*;
#(
    parameter int DATA_W       = TX_DATA_W,
    parameter int CLKS_PER_BIT = TX_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              TxData,
    input  logic [DATA_W-1:0] DataIn,
    output logic              SerialOut,
    output logic              TxDone,
    output logic              TxBusy
);

    // Index counter holds values up to DATA_W so it can never wrap mid-frame.
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    tx_state_t         state, state_next;
    logic [DATA_W-1:0] shift, shift_next;
    logic [IW-1:0]     idx, idx_next;
    logic              par, par_next;
    logic              serial_next;
    logic              load;
    logic              tick;

    tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk  (Clk),
        .Reset(Reset),
        .load (load),
        .tick (tick)
    );

    // State, datapath and the registered serial line.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            shift     <= '0;
            idx       <= '0;
            par       <= 1'b0;
            SerialOut <= 1'b1;
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            idx       <= idx_next;
            par       <= par_next;
            SerialOut <= serial_next;
        end
    end

    // Next-state logic; the line level is derived from where we are going so it is registered.
    always_comb begin
        state_next = state;
        shift_next = shift;
        idx_next   = idx;
        par_next   = par;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (TxData) begin
                    state_next = START;
                    shift_next = DataIn;
                    idx_next   = '0;
                    par_next   = ^DataIn;
                    load       = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    load       = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    load       = 1'b1;
                    shift_next = shift >> 1;
                    if (idx == LAST_IDX) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_next = idx + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                    load       = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[0];
            PARITY:  serial_next = par_next;
            default: serial_next = 1'b1;
        endcase
    end

    assign TxDone = (state == DONE);
    assign TxBusy = (state != IDLE);

endmodule

// File: tb/tb_data_tx_serializer.sv
// tb/tb_data_tx_serializer.sv - scoreboard bench for data_tx_serializer
module tb_data_tx_serializer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       tx0 = 1'b0, tx1 = 1'b0, tx2 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic       s0, s1, s2, dn0, dn1, dn2, b0, b1, b2;

    int total = 0;
    int bad = 0;
    logic [2:0] exp_q[$];

    always #5 Clk = ~Clk;

    data_tx_serializer dut0 (
        .Clk(Clk), .Reset(Reset), .TxData(tx0), .DataIn(d0),
        .SerialOut(s0), .TxDone(dn0), .TxBusy(b0)
    );

    data_tx_serializer #(.PARITY_EN(0)) dut1 (
        .Clk(Clk), .Reset(Reset), .TxData(tx1), .DataIn(d1),
        .SerialOut(s1), .TxDone(dn1), .TxBusy(b1)
    );

    data_tx_serializer #(.CLKS_PER_BIT(1)) dut2 (
        .Clk(Clk), .Reset(Reset), .TxData(tx2), .DataIn(d2),
        .SerialOut(s2), .TxDone(dn2), .TxBusy(b2)
    );

    function automatic logic [2:0] obs(input int i);
        case (i)
            0:       return {s0, dn0, b0};
            1:       return {s1, dn1, b1};
            default: return {s2, dn2, b2};
        endcase
    endfunction

    task automatic set_tx(input int i, input logic v);
        case (i)
            0:       tx0 = v;
            1:       tx1 = v;
            default: tx2 = v;
        endcase
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        case (i)
            0:       d0 = v;
            1:       d1 = v;
            default: d2 = v;
        endcase
    endtask

    // Expected {SerialOut, TxDone, TxBusy} for every cycle after the accept edge.
    task automatic push_frame(input logic [7:0] d, input int cpb, input bit par, input bit tail);
        logic bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (par) bits.push_back(^d);
        bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int n = 0; n < cpb; n++) exp_q.push_back({bits[k], 1'b0, 1'b1});
        end
        exp_q.push_back(3'b111);
        if (tail) exp_q.push_back(3'b100);
    endtask

    task automatic push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(3'b100);
    endtask

    task automatic start(input int i, input logic [7:0] d);
        @(negedge Clk);
        set_data(i, d);
        set_tx(i, 1'b1);
    endtask

    // Pops one expectation per cycle; mode adds mid-frame stimulus (1 ignore, 2 hold, 3 reset).
    task automatic check_q(input int i, input int mode, input string name);
        int c = 0;
        logic [2:0] exp, got;
        while (exp_q.size() > 0) begin
            @(negedge Clk);
            c++;
            exp = exp_q.pop_front();
            got = obs(i);
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s cycle %0d: serial/done/busy got %b expected %b", name, c, got, exp);
            end
            set_tx(i, 1'b0);
            if (mode == 1) begin
                if (c == 2) set_data(i, 8'hFF);
                if (c == 5 || c == 20) set_tx(i, 1'b1);
            end else if (mode == 2) begin
                if (c < 47) set_tx(i, 1'b1);
                if (c == 46) set_data(i, 8'hC3);
            end else if (mode == 3) begin
                if (c == 18) Reset = 1'b0;
                if (c == 19) Reset = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs(i) !== 3'b100) begin
                bad++;
                $display("FAIL reset dut%0d: got %b expected 100", i, obs(i));
            end
        end
        Reset = 1'b1;
    endtask

    task automatic test_basic;
        start(0, 8'hA5);
        push_frame(8'hA5, 4, 1'b1, 1'b1);
        check_q(0, 0, "frame_a5");
    endtask

    task automatic test_parity;
        start(0, 8'h07);
        push_frame(8'h07, 4, 1'b1, 1'b1);
        check_q(0, 0, "parity_07");
        start(1, 8'h07);
        push_frame(8'h07, 4, 1'b0, 1'b1);
        check_q(1, 0, "noparity_07");
    endtask

    task automatic test_ignore;
        start(0, 8'hA5);
        push_frame(8'hA5, 4, 1'b1, 1'b1);
        push_idle(3);
        check_q(0, 1, "ignore_txdata");
    endtask

    task automatic test_back_to_back;
        start(0, 8'h5A);
        push_frame(8'h5A, 4, 1'b1, 1'b0);
        push_idle(1);
        push_frame(8'hC3, 4, 1'b1, 1'b1);
        check_q(0, 2, "back_to_back");
    endtask

    task automatic test_reset_mid;
        start(0, 8'hA5);
        push_frame(8'hA5, 4, 1'b1, 1'b0);
        while (exp_q.size() > 18) void'(exp_q.pop_back());
        push_idle(50);
        check_q(0, 3, "reset_abort");
        start(0, 8'h3C);
        push_frame(8'h3C, 4, 1'b1, 1'b1);
        check_q(0, 0, "post_reset_3c");
    endtask

    task automatic test_cpb1;
        start(2, 8'h81);
        push_frame(8'h81, 1, 1'b1, 1'b1);
        check_q(2, 0, "cpb1_81");
        start(2, 8'h6E);
        push_frame(8'h6E, 1, 1'b1, 1'b1);
        check_q(2, 0, "cpb1_6e");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_ignore();
        test_back_to_back();
        test_reset_mid();
        test_cpb1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
